// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
//   din / din_valid / din_ready : parallel word handshake
//   hold                        : downstream stall
//   sout / sout_valid / done    : serial stream, bit qualifier, last-bit pulse
//   words_sent                  : running count of completed words
// master = word source / stream sink, slave = the serializer.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             hold;
   logic             sout;
   logic             sout_valid;
   logic             done;
   logic [15:0]      words_sent;

   modport master (
      output din, din_valid, hold,
      input  din_ready, sout, sout_valid, done, words_sent
   );

   modport slave (
      input  din, din_valid, hold,
      output din_ready, sout, sout_valid, done, words_sent
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input handshake and a
// downstream hold. One word of WIDTH bits is shifted out per WIDTH unstalled
// cycles; a new word may be accepted on the last-bit edge so consecutive words
// stream without a gap.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - bit_serializer_if.slave (din/din_valid/din_ready, hold,
//          sout/sout_valid/done, words_sent)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word loaded, sout=0, ready to accept
// SHIFT | word in sreg, cnt_q = index of bit currently on sout
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic             clk,
   input logic             rst,
   bit_serializer_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      words_q, words_d;

   logic             din_ready;
   logic             sout_valid;
   logic             done;
   logic [WIDTH-1:0] sreg_shifted;

   // Vacated bit fills with zero so an emptied register naturally reads sout=0.
   assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, sreg_q[WIDTH-1:1]};

   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      words_d    = words_q;
      din_ready  = 1'b0;
      sout_valid = 1'b0;
      done       = 1'b0;

      case (state_q)
         IDLE: begin
            // rst gating keeps din_ready low for the whole reset window.
            din_ready = !rst;
            if (bus.din_valid && din_ready) begin
               sreg_d  = bus.din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (!bus.hold) begin
               sout_valid = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  done      = 1'b1;
                  din_ready = !rst;
                  words_d   = words_q + 16'd1;
                  if (bus.din_valid && din_ready) begin
                     // Chain straight into the next word, no gap cycle.
                     sreg_d = bus.din;
                     cnt_d  = '0;
                  end else begin
                     sreg_d  = '0;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  sreg_d = sreg_shifted;
                  cnt_d  = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         words_q <= words_d;
      end
   end

   assign bus.sout       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
   assign bus.sout_valid = sout_valid;
   assign bus.done       = done;
   assign bus.din_ready  = din_ready;
   assign bus.words_sent = words_q;
endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   bit_serializer_if #(.WIDTH(8)) b1 ();
   bit_serializer_if #(.WIDTH(8)) b2 ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk (clk),
      .rst (rst),
      .bus (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus helper only: offers one word to dut and captures 8 cycles.
   task automatic send_one(input logic [7:0] w, output logic [7:0] bits,
                           output int ndone);
      b1.din       = w;
      b1.din_valid = 1'b1;
      @(negedge clk);
      b1.din_valid = 1'b0;
      bits  = '0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         bits = {bits[6:0], b1.sout};
         if (b1.done) ndone++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      n_cmp++; if (b1.din_ready !== 1'b0) begin n_bad++; $display("FAIL rst_din_ready: got %b expected 0", b1.din_ready); end
      n_cmp++; if (b1.sout !== 1'b0) begin n_bad++; $display("FAIL rst_sout: got %b expected 0", b1.sout); end
      n_cmp++; if (b1.sout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sout_valid: got %b expected 0", b1.sout_valid); end
      n_cmp++; if (b1.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", b1.done); end
      n_cmp++; if (b1.words_sent !== 16'h0000) begin n_bad++; $display("FAIL rst_words: got %h expected 0000", b1.words_sent); end
      rst = 1'b0;
      #1;
      n_cmp++; if (b1.din_ready !== 1'b1) begin n_bad++; $display("FAIL idle_din_ready: got %b expected 1", b1.din_ready); end
      n_cmp++; if (b2.din_ready !== 1'b1) begin n_bad++; $display("FAIL idle_din_ready_lsb: got %b expected 1", b2.din_ready); end
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] bits;
      int         ndone;
      b1.din       = 8'hD0;
      b1.din_valid = 1'b1;
      #1;
      n_cmp++; if (b1.sout_valid !== 1'b0) begin n_bad++; $display("FAIL single_pre_valid: got %b expected 0", b1.sout_valid); end
      @(negedge clk);
      b1.din_valid = 1'b0;
      bits  = '0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         bits = {bits[6:0], b1.sout};
         n_cmp++; if (b1.sout_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d]: got %b expected 1", i, b1.sout_valid); end
         n_cmp++; if (b1.done !== (i == 7)) begin n_bad++; $display("FAIL single_done[%0d]: got %b expected %b", i, b1.done, (i == 7)); end
         if (b1.done) ndone++;
         @(negedge clk);
      end
      #1;
      n_cmp++; if (bits !== 8'hD0) begin n_bad++; $display("FAIL single_bits: got %h expected d0", bits); end
      n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL single_ndone: got %0d expected 1", ndone); end
      n_cmp++; if (b1.words_sent !== 16'd1) begin n_bad++; $display("FAIL single_words: got %h expected 0001", b1.words_sent); end
      n_cmp++; if (b1.sout_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle_valid: got %b expected 0", b1.sout_valid); end
      n_cmp++; if (b1.sout !== 1'b0) begin n_bad++; $display("FAIL single_idle_sout: got %b expected 0", b1.sout); end
      n_cmp++; if (b1.din_ready !== 1'b1) begin n_bad++; $display("FAIL single_idle_ready: got %b expected 1", b1.din_ready); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [15:0] bits;
      int          ndone;
      b1.din       = 8'hA5;
      b1.din_valid = 1'b1;
      @(negedge clk);
      b1.din = 8'h3C;
      bits   = '0;
      ndone  = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) b1.din_valid = 1'b0;
         #1;
         bits = {bits[14:0], b1.sout};
         if (b1.done) ndone++;
         n_cmp++; if (b1.sout_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, b1.sout_valid); end
         n_cmp++; if (b1.din_ready !== (i == 7 || i == 15)) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, b1.din_ready, (i == 7 || i == 15)); end
         @(negedge clk);
      end
      #1;
      n_cmp++; if (bits !== 16'hA53C) begin n_bad++; $display("FAIL b2b_bits: got %h expected a53c", bits); end
      n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL b2b_ndone: got %0d expected 2", ndone); end
      n_cmp++; if (b1.words_sent !== 16'd3) begin n_bad++; $display("FAIL b2b_words: got %h expected 0003", b1.words_sent); end
      n_cmp++; if (b1.sout_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_valid: got %b expected 0", b1.sout_valid); end
      @(negedge clk);
   endtask

   task automatic test_hold();
      logic [7:0] bits;
      int         nvalid;
      int         ndone;
      logic       hold_now;
      // Acceptance with hold=1 in IDLE must still happen.
      b1.din       = 8'hF0;
      b1.din_valid = 1'b1;
      b1.hold      = 1'b1;
      #1;
      n_cmp++; if (b1.din_ready !== 1'b1) begin n_bad++; $display("FAIL hold_idle_ready: got %b expected 1", b1.din_ready); end
      @(negedge clk);
      b1.din_valid = 1'b0;
      bits   = '0;
      nvalid = 0;
      ndone  = 0;
      for (int c = 0; c < 11; c++) begin
         hold_now = (c >= 4 && c <= 6);
         b1.hold  = hold_now;
         #1;
         if (b1.sout_valid) begin
            bits = {bits[6:0], b1.sout};
            nvalid++;
         end
         if (b1.done) ndone++;
         n_cmp++; if (b1.sout_valid !== !hold_now) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b expected %b", c, b1.sout_valid, !hold_now); end
         if (hold_now) begin
            n_cmp++; if (b1.din_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b expected 0", c, b1.din_ready); end
         end
         @(negedge clk);
      end
      b1.hold = 1'b0;
      #1;
      n_cmp++; if (bits !== 8'hF0) begin n_bad++; $display("FAIL hold_bits: got %h expected f0", bits); end
      n_cmp++; if (nvalid !== 8) begin n_bad++; $display("FAIL hold_nvalid: got %0d expected 8", nvalid); end
      n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL hold_ndone: got %0d expected 1", ndone); end
      n_cmp++; if (b1.words_sent !== 16'd4) begin n_bad++; $display("FAIL hold_words: got %h expected 0004", b1.words_sent); end
      @(negedge clk);
   endtask

   task automatic test_lsb_first();
      logic [7:0] bits;
      int         ndone;
      b2.din       = 8'h0B;
      b2.din_valid = 1'b1;
      @(negedge clk);
      b2.din_valid = 1'b0;
      bits  = '0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         bits = {bits[6:0], b2.sout};
         if (b2.done) ndone++;
         n_cmp++; if (b2.sout_valid !== 1'b1) begin n_bad++; $display("FAIL lsb_valid[%0d]: got %b expected 1", i, b2.sout_valid); end
         @(negedge clk);
      end
      #1;
      // Sequence 1,1,0,1,0,0,0,0 packed first-bit-leftmost.
      n_cmp++; if (bits !== 8'hD0) begin n_bad++; $display("FAIL lsb_bits: got %h expected d0", bits); end
      n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL lsb_ndone: got %0d expected 1", ndone); end
      n_cmp++; if (b2.words_sent !== 16'd1) begin n_bad++; $display("FAIL lsb_words: got %h expected 0001", b2.words_sent); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_word();
      b1.din       = 8'hFF;
      b1.din_valid = 1'b1;
      @(negedge clk);
      b1.din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (b1.done !== 1'b0) begin n_bad++; $display("FAIL mid_done[%0d]: got %b expected 0", i, b1.done); end
         @(negedge clk);
      end
      // 5th bit on sout; assert reset well before the next rising edge.
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (b1.sout !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sout: got %b expected 0", b1.sout); end
      n_cmp++; if (b1.sout_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", b1.sout_valid); end
      n_cmp++; if (b1.done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b expected 0", b1.done); end
      n_cmp++; if (b1.din_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0", b1.din_ready); end
      n_cmp++; if (b1.words_sent !== 16'd0) begin n_bad++; $display("FAIL mid_rst_words: got %h expected 0000", b1.words_sent); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++; if (b1.din_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready[%0d]: got %b expected 1", i, b1.din_ready); end
         n_cmp++; if (b1.sout_valid !== 1'b0 || b1.done !== 1'b0) begin n_bad++; $display("FAIL post_rst_quiet[%0d]: got valid=%b done=%b expected 0 0", i, b1.sout_valid, b1.done); end
         @(negedge clk);
      end
      #1;
      n_cmp++; if (b1.words_sent !== 16'd0) begin n_bad++; $display("FAIL post_rst_words: got %h expected 0000", b1.words_sent); end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [7:0] bits;
      int         ndone;
      // Preload the counter near the top instead of streaming 65534 words.
      force dut.words_q = 16'hFFFE;
      #1;
      release dut.words_q;
      @(negedge clk);
      #1;
      n_cmp++; if (b1.words_sent !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_preload: got %h expected fffe", b1.words_sent); end
      @(negedge clk);
      send_one(8'h81, bits, ndone);
      #1;
      n_cmp++; if (b1.words_sent !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_ffff: got %h expected ffff", b1.words_sent); end
      n_cmp++; if (bits !== 8'h81) begin n_bad++; $display("FAIL wrap_bits1: got %h expected 81", bits); end
      @(negedge clk);
      send_one(8'h5A, bits, ndone);
      #1;
      n_cmp++; if (b1.words_sent !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero: got %h expected 0000", b1.words_sent); end
      n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL wrap_ndone: got %0d expected 1", ndone); end
      n_cmp++; if (bits !== 8'h5A) begin n_bad++; $display("FAIL wrap_bits2: got %h expected 5a", bits); end
      @(negedge clk);
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      b1.din       = '0;
      b1.din_valid = 1'b0;
      b1.hold      = 1'b0;
      b2.din       = '0;
      b2.din_valid = 1'b0;
      b2.hold      = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_lsb_first();
      test_reset_mid_word();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
